modulation_segment_accumulate: RTL
==================================

// Module: modulation_segment_accumulate
// PURPOSE
//  Downstream stage of the if/else segment calculators in the modulation pipe. Consumes the
//  delayed segment words they produce, one per seg_valid beat, and sums NUM_SEG of them.
//  The sign of each contribution is chosen by input_bit vs zero, latched at start.
//  Emits one signed, saturated modulated symbol per start/valid transaction.
// PARAMETERS
//  NUM_SEG   4    segments summed per symbol (2..16)
//  TIMEOUT   64   max idle cycles between seg_valid beats before abort (>=2)
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  start        in   1   begin a symbol; sampled only in IDLE
//  input_bit    in   32  modulation bit word; latched at accepted start
//  zero         in   32  comparison reference; latched at accepted start
//  segment_in   in   32  signed segment word from the if/else calculators
//  seg_valid    in   1   segment_in valid this cycle
//  result       out  32  signed saturated symbol; held until next accepted start
//  valid        out  1   one-cycle pulse: result is final
//  busy         out  1   high from accepted start until the cycle valid or error pulses
//  overflow     out  1   sticky per symbol: saturation occurred; cleared at next start
//  error        out  1   one-cycle pulse: timeout abort
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, result=0, valid=0, busy=0, overflow=0, error=0,
//   acc=0, seg_cnt=0, idle_cnt=0. Reset mid-symbol discards all progress immediately.
//  States: IDLE, COLLECT, DONE, ABORT.
//  IDLE: start=1 -> latch neg = (input_bit == zero), clear acc/seg_cnt/idle_cnt/overflow,
//   busy=1 next cycle, go COLLECT. seg_valid in IDLE is ignored.
//  COLLECT: each seg_valid beat: acc <= sat32(acc + (neg ? -segment_in : segment_in)),
//   seg_cnt++, idle_cnt=0. Negating 0x80000000 gives 0x7FFFFFFF (saturated, sets overflow).
//   Sum is computed in 34-bit signed and clamped to [0x80000000, 0x7FFFFFFF]; clamp sets overflow.
//   No beat: idle_cnt++. idle_cnt reaching TIMEOUT-1 with no beat -> ABORT.
//   Beat that makes seg_cnt==NUM_SEG -> DONE.
//  DONE (one cycle): result<=acc, valid=1, busy=0, -> IDLE. Latency from final beat
//   to valid = 1 cycle; result updates in the same cycle valid is high.
//  ABORT (one cycle): error=1, busy=0, result unchanged, -> IDLE.
//  start while busy: ignored (no re-latch, no restart).
//  start in the DONE/ABORT cycle: ignored; accepted from the following IDLE cycle.
//  seg_valid and timeout in same cycle: beat wins, idle_cnt clears.
//  seg_valid during DONE/ABORT: dropped.
//  Minimum symbol period: NUM_SEG+2 cycles (start, NUM_SEG beats, DONE).
// TESTING
//  1 NUM_SEG=4, input_bit=1, zero=0, segments 10,20,30,40 back-to-back -> valid 1 cycle
//    after 4th beat, result=100, overflow=0, busy low same cycle as valid.
//  2 input_bit=5, zero=5, segments 1,2,3,4 -> result=-10 (0xFFFFFFF6).
//  3 segments 0x7FFFFFF0 x4 with neg=0 -> result=0x7FFFFFFF, overflow=1; next start clears
//    overflow; segment 0x80000000 with neg=1 -> clamps to 0x7FFFFFFF, overflow=1.
//  4 Two beats then seg_valid held low TIMEOUT cycles -> error pulse, busy=0, result holds
//    previous symbol value, valid never pulses.
//  5 start pulsed mid-COLLECT with new input_bit -> ignored; sign and count unchanged.
//  6 reset asserted after 2 beats -> all outputs 0 asynchronously; new symbol after
//    release sums only its own segments.

Source files
------------

// File: rtl/modulation_segment_accumulate_if.sv
// modulation_segment_accumulate_if: symbol request, segment stream and result bus
//   start/input_bit/zero  : symbol request and sign operands (master -> slave)
//   segment_in/seg_valid  : signed segment stream (master -> slave)
//   result/valid/busy/overflow/error : symbol outcome and status (slave -> master)
interface modulation_segment_accumulate_if;
   logic        start;
   logic [31:0] input_bit;
   logic [31:0] zero;
   logic [31:0] segment_in;
   logic        seg_valid;
   logic [31:0] result;
   logic        valid;
   logic        busy;
   logic        overflow;
   logic        error;
   modport master (output start, input_bit, zero, segment_in, seg_valid,
                   input result, valid, busy, overflow, error);
   modport slave (input start, input_bit, zero, segment_in, seg_valid,
                  output result, valid, busy, overflow, error);
endinterface

// File: rtl/modulation_segment_accumulate.sv
// modulation_segment_accumulate: sums NUM_SEG signed segments per symbol with a latched sign and saturation
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : request, segment stream and result/status signals (slave side)
module modulation_segment_accumulate #(
   parameter int NUM_SEG = 4,
   parameter int TIMEOUT = 64
) (
   input logic clk,
   input logic reset,
   modulation_segment_accumulate_if.slave bus
);
   localparam int SW = $clog2(NUM_SEG);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [SW-1:0] SEG_LAST = SW'(NUM_SEG - 1);
   localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);
   typedef enum logic [1:0] {IDLE, COLLECT, DONE, ABORT} state_t;
   state_t state;
   logic neg;
   logic [31:0] acc;
   logic [SW-1:0] seg_cnt;
   logic [TW-1:0] idle_cnt;
   logic neg_ovf;
   logic sat_ovf;
   logic [31:0] term;
   logic [33:0] sum;
   logic [31:0] acc_nx;
   // Negating the most negative word cannot be represented, so it clamps and counts as overflow.
   always_comb begin
      neg_ovf = neg && bus.segment_in == 32'h8000_0000;
      term = !neg ? bus.segment_in : neg_ovf ? 32'h7FFF_FFFF : -bus.segment_in;
      sum = {{2{acc[31]}}, acc} + {{2{term[31]}}, term};
      sat_ovf = sum[33:31] != 3'b000 && sum[33:31] != 3'b111;
      acc_nx = !sat_ovf ? sum[31:0] : sum[33] ? 32'h8000_0000 : 32'h7FFF_FFFF;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         neg <= 1'b0;
         acc <= '0;
         seg_cnt <= '0;
         idle_cnt <= '0;
         bus.result <= '0;
         bus.valid <= 1'b0;
         bus.busy <= 1'b0;
         bus.overflow <= 1'b0;
         bus.error <= 1'b0;
      end else begin
         bus.valid <= 1'b0;
         bus.error <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               neg <= bus.input_bit == bus.zero;
               acc <= '0;
               seg_cnt <= '0;
               idle_cnt <= '0;
               bus.overflow <= 1'b0;
               bus.busy <= 1'b1;
               state <= COLLECT;
            end
            COLLECT: if (bus.seg_valid) begin
               acc <= acc_nx;
               bus.overflow <= bus.overflow | neg_ovf | sat_ovf;
               seg_cnt <= seg_cnt + 1'b1;
               idle_cnt <= '0;
               // Outputs are registered on the final beat so valid/result appear in the DONE cycle.
               if (seg_cnt == SEG_LAST) begin
                  bus.result <= acc_nx;
                  bus.valid <= 1'b1;
                  bus.busy <= 1'b0;
                  state <= DONE;
               end
            end else if (idle_cnt == IDLE_LAST) begin
               bus.error <= 1'b1;
               bus.busy <= 1'b0;
               state <= ABORT;
            end else begin
               idle_cnt <= idle_cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
